ap_cpa_pipe: RTL and testbench

- Final carry-propagate stage of the approximate multiplier. It sits directly downstream of the ap_com_* compressor tree.
- Consumes the two reduced rows (sum row, carry row) that the compressor tree produces and adds them into the final product.
- Two-stage pipelined split adder with a valid/ready handshake, so the combinational tree can be registered and back-pressured.

---
 rtl/ap_cpa_pipe.sv | 126 ++++++++++++
 tb/tb_ap_cpa_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_cpa_pipe.sv
// Two-stage pipelined split carry-propagate adder for the approximate multiplier's final rows.
// Optional completed-transaction counter enabled by defining AP_CPA_STATS_EN.
module ap_cpa_pipe #(
    parameter int W  = 16,
    parameter int LO = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_row_a,
    input  logic [W-1:0] in_row_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_prod,
    output logic         out_cout,
    output logic         busy
`ifdef AP_CPA_STATS_EN
    ,
    output logic [15:0]  stat_cnt
`endif
);

    localparam int HW = W - LO;

    logic          r_s1_valid;
    logic          r_s2_valid;
    logic [LO:0]   r_lo;
    logic [HW-1:0] r_a_hi;
    logic [HW-1:0] r_b_hi;
    logic [W-1:0]  r_prod;
    logic          r_cout;

    logic          w_s2_free;
    logic          w_s1_adv;
    logic          w_accept;
    logic          w_s1_valid_nxt;
    logic          w_s2_valid_nxt;
    logic [HW:0]   w_hi;

    // Handshake decode and next-state valids
    always_comb begin
        w_s2_free      = 1'b0;
        w_s1_adv       = 1'b0;
        w_accept       = 1'b0;
        w_s1_valid_nxt = 1'b0;
        w_s2_valid_nxt = 1'b0;
        w_hi           = '0;
        w_s2_free      = !r_s2_valid | out_ready;
        w_s1_adv       = r_s1_valid & w_s2_free;
        w_accept       = in_valid & (!r_s1_valid | w_s2_free);
        w_s1_valid_nxt = w_accept | (r_s1_valid & !w_s1_adv);
        w_s2_valid_nxt = w_s1_adv | (r_s2_valid & !out_ready);
        // Upper half completes using the carry registered out of the low half
        w_hi = {1'b0, r_a_hi} + {1'b0, r_b_hi} + {{HW{1'b0}}, r_lo[LO]};
    end

    // Stage occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_s1_valid_nxt;
            r_s2_valid <= w_s2_valid_nxt;
        end
    end

    // Stage 1: low-half sum plus raw high halves, loaded only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo   <= '0;
            r_a_hi <= '0;
            r_b_hi <= '0;
        end else if (w_accept) begin
            r_lo   <= {1'b0, in_row_a[LO-1:0]} + {1'b0, in_row_b[LO-1:0]};
            r_a_hi <= in_row_a[W-1:LO];
            r_b_hi <= in_row_b[W-1:LO];
        end else begin
            r_lo   <= r_lo;
            r_a_hi <= r_a_hi;
            r_b_hi <= r_b_hi;
        end
    end

    // Stage 2: final product, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_cout <= 1'b0;
        end else if (w_s1_adv) begin
            r_prod <= {w_hi[HW-1:0], r_lo[LO-1:0]};
            r_cout <= w_hi[HW];
        end else begin
            r_prod <= r_prod;
            r_cout <= r_cout;
        end
    end

    assign in_ready  = !r_s1_valid | w_s2_free;
    assign out_valid = r_s2_valid;
    assign out_prod  = r_prod;
    assign out_cout  = r_cout;
    assign busy      = r_s1_valid | r_s2_valid;

`ifdef AP_CPA_STATS_EN
    logic [15:0] r_stat_cnt;
    logic        w_xfer;

    assign w_xfer = r_s2_valid & out_ready;

    // Saturating count of output transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cnt <= 16'h0000;
        end else if (w_xfer && (r_stat_cnt != 16'hFFFF)) begin
            r_stat_cnt <= r_stat_cnt + 16'h0001;
        end else begin
            r_stat_cnt <= r_stat_cnt;
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_ap_cpa_pipe.sv
// Directed self-checking bench for ap_cpa_pipe (W=16, LO=8).
// Stats checks compile in only when AP_CPA_STATS_EN is defined.
module tb_ap_cpa_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_row_a;
    logic [15:0] in_row_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        out_cout;
    logic        busy;
`ifdef AP_CPA_STATS_EN
    logic [15:0] stat_cnt;
`endif

    int errs;
    int checks;

    ap_cpa_pipe #(.W(16), .LO(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row_a  (in_row_a),
        .in_row_b  (in_row_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef AP_CPA_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row_a  = 16'h0000;
        in_row_b  = 16'h0000;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row_a  = 16'h0000;
        in_row_b  = 16'h0000;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if ({out_cout, out_prod} !== 17'h0_0000) begin
            errs++; $display("FAIL reset_data got=%b/%h exp=0/0000", out_cout, out_prod);
        end
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_latency();
        in_valid = 1'b1; in_row_a = 16'h00FF; in_row_b = 16'h0001; out_ready = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
        checks++;
        if ({out_cout, out_prod} !== {1'b0, 16'h0100}) begin
            errs++; $display("FAIL lat_data got=%b/%h exp=0/0100", out_cout, out_prod);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL lat_valid_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_carry_split();
        in_valid = 1'b1; in_row_a = 16'hFFFF; in_row_b = 16'h0001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, out_cout, out_prod} !== {1'b1, 1'b1, 16'h0000}) begin
            errs++; $display("FAIL carry_split got=v%b c%b %h exp=v1 c1 0000", out_valid, out_cout, out_prod);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] ep [4];
        logic        ec [4];
        va[0] = 16'h0001; vb[0] = 16'h0002; ep[0] = 16'h0003; ec[0] = 1'b0;
        va[1] = 16'h0003; vb[1] = 16'h0004; ep[1] = 16'h0007; ec[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h8000; ep[2] = 16'h0000; ec[2] = 1'b1;
        va[3] = 16'h1234; vb[3] = 16'h4321; ep[3] = 16'h5555; ec[3] = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            if (n < 4) begin
                in_valid = 1'b1; in_row_a = va[n]; in_row_b = vb[n];
                checks++;
                if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", n, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            if (n >= 2 && n < 6) begin
                checks++;
                if ({out_valid, out_cout, out_prod} !== {1'b1, ec[n-2], ep[n-2]}) begin
                    errs++;
                    $display("FAIL b2b_out[%0d] got=v%b c%b %h exp=v1 c%b %h",
                             n - 2, out_valid, out_cout, out_prod, ec[n-2], ep[n-2]);
                end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_row_a = 16'h0010; in_row_b = 16'h0020;
        step();
        in_row_a = 16'h00F0; in_row_b = 16'h0F10;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_second_ready got=%b exp=1", in_ready); end
        step();
        in_row_a = 16'hFF00; in_row_b = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, out_valid, busy, out_cout, out_prod} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0030}) begin
                errs++;
                $display("FAIL stall_hold[%0d] got=rdy%b v%b busy%b c%b %h exp=rdy0 v1 busy1 c0 0030",
                         i, in_ready, out_valid, busy, out_cout, out_prod);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_cout, out_prod} !== {1'b1, 1'b0, 16'h1000}) begin
            errs++; $display("FAIL stall_second got=v%b c%b %h exp=v1 c0 1000", out_valid, out_cout, out_prod);
        end
        step();
        checks++;
        if ({out_valid, out_cout, out_prod} !== {1'b1, 1'b1, 16'h0000}) begin
            errs++; $display("FAIL stall_third got=v%b c%b %h exp=v1 c1 0000", out_valid, out_cout, out_prod);
        end
        step();
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errs++; $display("FAIL stall_drain got=v%b busy%b exp=v0 busy0", out_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_row_a = 16'h0101; in_row_b = 16'h0202;
        step();
        in_row_a = 16'h0303; in_row_b = 16'h0404;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b11) begin
            errs++; $display("FAIL arst_pre got=v%b busy%b exp=v1 busy1", out_valid, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errs++; $display("FAIL arst_immediate got=v%b busy%b rdy%b exp=v0 busy0 rdy1", out_valid, busy, in_ready);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                errs++; $display("FAIL arst_stale[%0d] got=v%b busy%b exp=v0 busy0", i, out_valid, busy);
            end
        end
    endtask

`ifdef AP_CPA_STATS_EN
    task automatic run_transfers(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_row_a = 16'(i); in_row_b = 16'h0001;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_stats();
        do_reset();
        checks++;
        if (stat_cnt !== 16'h0000) begin errs++; $display("FAIL stats_reset got=%h exp=0000", stat_cnt); end
        run_transfers(3);
        checks++;
        if (stat_cnt !== 16'h0003) begin errs++; $display("FAIL stats_three got=%h exp=0003", stat_cnt); end
        force dut.r_stat_cnt = 16'hFFFE;
        #1;
        release dut.r_stat_cnt;
        run_transfers(3);
        checks++;
        if (stat_cnt !== 16'hFFFF) begin errs++; $display("FAIL stats_saturate got=%h exp=FFFF", stat_cnt); end
    endtask
`endif

    initial begin
        errs   = 0;
        checks = 0;
        test_reset();
        test_latency();
        test_carry_split();
        test_back_to_back();
        test_stall();
        test_async_reset();
`ifdef AP_CPA_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
